// File: rtl/channel_feeder_288_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | channel_feeder_288_pkg                                               |
// | Shared state encoding, window geometry and element width.            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
// Fallback element width when num_data.v has not been included first.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

package channel_feeder_288_pkg;

  localparam int c_DATA_LEN     = `DATA_LEN;
  localparam int c_BEATS        = 9;
  localparam int c_LANES        = 32;
  localparam int c_WINDOW_ELEMS = 288;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_NEXT = 2'd3
  } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/channel_feeder_288_window.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | channel_feeder_288_window                                            |
// | Window register: one slot per beat, written on accept, else held.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module channel_feeder_288_window #(
  parameter int BEATS  = 9,
  parameter int LANES  = 32,
  parameter int DW     = 8,
  parameter int SLOT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [SLOT_W-1:0]           wr_slot,
  input  logic [LANES*DW-1:0]         wr_data,
  output logic [BEATS*LANES*DW-1:0]   d
);

  localparam int c_BEAT_W = LANES * DW;

  for (genvar k = 0; k < BEATS; k++) begin : g_slot
    localparam logic [SLOT_W-1:0] c_SLOT = SLOT_W'(k);
    logic [c_BEAT_W-1:0] r_slot;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_slot <= '0;
      end else if (wr_en && (wr_slot == c_SLOT)) begin
        r_slot <= wr_data;
      end
    end

    assign d[k*c_BEAT_W +: c_BEAT_W] = r_slot;
  end

endmodule

`default_nettype wire

// File: rtl/channel_feeder_288.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | channel_feeder_288                                                   |
// | Fills a 288-element window, steps the dot channel through NUM_CS     |
// | weight sets and emits one tagged result per set.                     |
// | Optional watchdog: define FEEDER_TIMEOUT_EN.                         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module channel_feeder_288
  import channel_feeder_288_pkg::*;
#(
  parameter int NUM_CS      = 8,
  parameter int BEATS       = c_BEATS,
  parameter int LANES       = c_LANES,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*c_DATA_LEN-1:0]          in_data,
  output logic                                 load,
  output logic [3:0]                           cs,
  output logic [c_WINDOW_ELEMS*c_DATA_LEN-1:0] d,
  input  logic                                 dot_valid,
  input  logic [c_DATA_LEN-1:0]                dot_q,
  output logic                                 res_valid,
  output logic [3:0]                           res_cs,
  output logic [c_DATA_LEN-1:0]                res_q,
  output logic                                 err
);

  localparam int               c_BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [c_BCW-1:0] c_LAST_BEAT = c_BCW'(BEATS - 1);
  localparam logic [3:0]       c_LAST_CS   = 4'(NUM_CS - 1);

  feeder_state_e         r_state, w_next;
  logic [c_BCW-1:0]      r_beat_cnt;
  logic [3:0]            r_cs, r_res_cs;
  logic [c_DATA_LEN-1:0] r_res_q;
  logic                  r_in_ready, r_res_valid;
  logic                  w_accept, w_last_beat, w_last_cs, w_timeout;

  assign w_accept    = in_valid & r_in_ready;
  assign w_last_beat = w_accept && (r_beat_cnt == c_LAST_BEAT);
  assign w_last_cs   = (r_cs == c_LAST_CS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FILL: if (w_last_beat) w_next = ST_ARM;
      ST_ARM:  w_next = ST_RUN;
      ST_RUN:  if (dot_valid || w_timeout) w_next = ST_NEXT;
      ST_NEXT: w_next = w_last_cs ? ST_FILL : ST_ARM;
      default: w_next = ST_FILL;
    endcase
  end

  // in_ready is registered from the next state so it is 0 while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_beat_cnt  <= '0;
      r_cs        <= '0;
      r_res_valid <= 1'b0;
      r_res_cs    <= '0;
      r_res_q     <= '0;
    end else begin
      r_in_ready  <= (w_next == ST_FILL);
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      end
      if (w_last_beat) begin
        r_cs <= '0;
      end else if ((r_state == ST_NEXT) && !w_last_cs) begin
        r_cs <= r_cs + 4'd1;
      end
      if ((r_state == ST_RUN) && dot_valid) begin
        r_res_valid <= 1'b1;
        r_res_cs    <= r_cs;
        r_res_q     <= dot_q;
      end
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int             c_WDW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT_CYC - 1);

  logic [c_WDW-1:0] r_wd;
  logic             r_err;

  // A dot_valid arriving on the final allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == ST_RUN) && !dot_valid && (r_wd == c_WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_ARM)      r_wd <= '0;
      else if (r_state == ST_RUN) r_wd <= r_wd + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  channel_feeder_288_window #(
    .BEATS  (BEATS),
    .LANES  (LANES),
    .DW     (c_DATA_LEN),
    .SLOT_W (c_BCW)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_accept),
    .wr_slot (r_beat_cnt),
    .wr_data (in_data),
    .d       (d)
  );

  assign in_ready  = r_in_ready;
  assign load      = (r_state == ST_RUN);
  assign cs        = r_cs;
  assign res_valid = r_res_valid;
  assign res_cs    = r_res_cs;
  assign res_q     = r_res_q;

endmodule

`default_nettype wire

// File: tb/tb_channel_feeder_288.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_channel_feeder_288                                                |
// | Directed bench with a behavioural window/result model and a simple   |
// | dot-channel responder.                                               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_channel_feeder_288;
  import channel_feeder_288_pkg::*;

  localparam int DW     = c_DATA_LEN;
  localparam int BEATS  = 9;
  localparam int LANES  = 32;
  localparam int NUM_CS = 8;
  localparam int c_TO   = 20;
  localparam int c_BW   = LANES * DW;
  localparam int c_WW   = c_WINDOW_ELEMS * DW;
`ifdef FEEDER_TIMEOUT_EN
  localparam bit c_TO_EN = 1'b1;
`else
  localparam bit c_TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, load, dot_valid, res_valid, err;
  logic [c_BW-1:0] in_data;
  logic [3:0]      cs, res_cs;
  logic [c_WW-1:0] d;
  logic [DW-1:0]   dot_q, res_q;

  int n_chk  = 0;
  int n_fail = 0;

  channel_feeder_288 #(
    .NUM_CS(NUM_CS), .BEATS(BEATS), .LANES(LANES), .TIMEOUT_CYC(c_TO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .load(load), .cs(cs), .d(d), .dot_valid(dot_valid),
    .dot_q(dot_q), .res_valid(res_valid), .res_cs(res_cs), .res_q(res_q),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] d_elem(input int i);
    return d[i*DW +: DW];
  endfunction

  function automatic logic [c_BW-1:0] beat_word(input int b);
    logic [c_BW-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*DW +: DW] = DW'(b * LANES + l);
    return w;
  endfunction

  // ---------------- dot channel responder ----------------
  int   dcnt = 0;
  logic spur_en = 1'b0, silent_en = 1'b0;
  logic [3:0] silent_cs = 4'd0;
  always @(negedge clk) begin
    if (load === 1'b1) dcnt++;
    else dcnt = 0;
    dot_valid = ((dcnt == 13) && !(silent_en && cs == silent_cs)) || (spur_en && load !== 1'b1);
    dot_q     = DW'(int'(cs) + 100);
  end

  // ---------------- behavioural model ----------------
  // The window is "full" once BEATS beats are in; each weight set then gets
  // one idle cycle, a loaded phase ended by dot_valid (or timeout), and one idle cycle.
  bit              m_full, m_pre, m_loaded, m_post, m_acc;
  int              m_nbeats, m_cs, m_runcyc;
  logic            e_ready, e_load, e_res_valid, e_err;
  logic [3:0]      e_res_cs;
  logic [DW-1:0]   e_res_q;
  logic [c_WW-1:0] e_win;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full = 0; m_pre = 0; m_loaded = 0; m_post = 0;
      m_nbeats = 0; m_cs = 0; m_runcyc = 0;
      e_ready = 0; e_load = 0; e_res_valid = 0; e_res_cs = '0; e_res_q = '0;
      e_err = 0; e_win = '0;
    end else begin
      m_acc = in_valid && e_ready;
      e_res_valid = 0;
      if (!m_full) begin
        if (m_acc) begin
          e_win[m_nbeats*c_BW +: c_BW] = in_data;
          m_nbeats++;
          if (m_nbeats == BEATS) begin
            m_full = 1; m_nbeats = 0; m_cs = 0; m_pre = 1;
          end
        end
      end else if (m_pre) begin
        m_pre = 0; m_loaded = 1; m_runcyc = 0;
      end else if (m_loaded) begin
        m_runcyc++;
        if (dot_valid) begin
          e_res_valid = 1; e_res_cs = 4'(m_cs); e_res_q = dot_q;
          m_loaded = 0; m_post = 1;
        end else if (c_TO_EN && m_runcyc == c_TO) begin
          e_err = 1; m_loaded = 0; m_post = 1;
        end
      end else if (m_post) begin
        m_post = 0;
        if (m_cs == NUM_CS - 1) m_full = 0;
        else begin m_cs++; m_pre = 1; end
      end
      e_ready = !m_full;
      e_load  = m_loaded;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0]    got_cs[$];
  logic [DW-1:0] got_q[$];
  always @(posedge clk) begin
    #2;
    chk("in_ready", 64'(in_ready), 64'(e_ready));
    chk("load", 64'(load), 64'(e_load));
    chk("cs", 64'(cs), 64'(m_cs));
    chk("res_valid", 64'(res_valid), 64'(e_res_valid));
    chk("res_cs", 64'(res_cs), 64'(e_res_cs));
    chk("res_q", 64'(res_q), 64'(e_res_q));
    chk("err", 64'(err), 64'(e_err));
    n_chk++;
    if (d !== e_win) begin
      n_fail++;
      for (int i = 0; i < c_WINDOW_ELEMS; i++)
        if (d[i*DW +: DW] !== e_win[i*DW +: DW]) begin
          $display("FAIL d_window: element %0d got 0x%0h, expected 0x%0h at %0t",
                   i, d[i*DW +: DW], e_win[i*DW +: DW], $time);
          break;
        end
    end
    if (res_valid === 1'b1) begin
      got_cs.push_back(res_cs);
      got_q.push_back(res_q);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_window(input bit toggle, input int stop_after, input string tag);
    int  bi  = 0;
    int  cyc = 0;
    bit  ph  = 0;
    while (bi < stop_after && cyc < 400) begin
      @(negedge clk);
      ph       = ~ph;
      in_valid = toggle ? ph : 1'b1;
      in_data  = beat_word(bi);
      if (in_valid && in_ready) bi++;
      cyc++;
    end
    chk({tag, "_beats_taken"}, 64'(bi), 64'(stop_after));
    @(negedge clk);
    in_valid = 1'b0;
    if (stop_after == BEATS) begin
      chk({tag, "_arm_load"}, 64'(load), 64'd0);
      chk({tag, "_arm_cs"}, 64'(cs), 64'd0);
      chk({tag, "_arm_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      chk({tag, "_load_rise"}, 64'(load), 64'd1);
    end
  endtask

  task automatic wait_ready(input int bound, input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_elems(input string tag);
    chk({tag, "_d0"}, 64'(d_elem(0)), 64'd0);
    chk({tag, "_d37"}, 64'(d_elem(37)), 64'd37);
    chk({tag, "_d200"}, 64'(d_elem(200)), 64'd200);
    chk({tag, "_d287"}, 64'(d_elem(287)), 64'd31);  // 287 mod 256
  endtask

  task automatic check_results(input int skip, input string tag);
    int k = 0;
    chk({tag, "_res_count"}, 64'(got_cs.size()), 64'((skip < 0) ? NUM_CS : NUM_CS - 1));
    for (int c = 0; c < NUM_CS; c++) begin
      if (c == skip) continue;
      if (k < got_cs.size()) begin
        chk({tag, "_res_cs_list"}, 64'(got_cs[k]), 64'(c));
        chk({tag, "_res_q_list"}, 64'(got_q[k]), 64'(c + 100));
      end
      k++;
    end
  endtask

  task automatic wait_cs_run(input logic [3:0] c, input string tag);
    int n = 0;
    while (!(load === 1'b1 && cs == c) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach_cs"}, 64'(cs), 64'(c));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_d_zero", 64'(d == '0), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Window 1: continuous valid, junk offered during RUN
    got_cs.delete(); got_q.delete();
    send_window(1'b0, BEATS, "w1");
    check_elems("w1");
    in_valid = 1'b1; in_data = '1;
    repeat (5) @(negedge clk);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    check_elems("w1_hold");
    in_valid = 1'b0;
    wait_ready(2000, "w1");
    check_results(-1, "w1");

    // Window 2: valid toggling, spurious dot_valid whenever load is low
    spur_en = 1'b1;
    got_cs.delete(); got_q.delete();
    send_window(1'b1, BEATS, "w2");
    check_elems("w2");
    wait_ready(2000, "w2");
    spur_en = 1'b0;
    @(negedge clk);
    check_results(-1, "w2");

    // Reset after 5 beats
    send_window(1'b0, 5, "rA");
    rst = 1'b1;
    #1;
    chk("rA_ready", 64'(in_ready), 64'd0);
    chk("rA_d_zero", 64'(d == '0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_cs.delete(); got_q.delete();
    send_window(1'b0, BEATS, "rA_w");
    check_elems("rA_w");
    wait_ready(2000, "rA_w");
    check_results(-1, "rA_w");

    // Reset in RUN at cs=3
    send_window(1'b0, BEATS, "rB");
    wait_cs_run(4'd3, "rB");
    rst = 1'b1;
    #1;
    chk("rB_cs", 64'(cs), 64'd0);
    chk("rB_load", 64'(load), 64'd0);
    chk("rB_res_q", 64'(res_q), 64'd0);
    chk("rB_res_cs", 64'(res_cs), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_cs.delete(); got_q.delete();
    send_window(1'b0, BEATS, "rB_w");
    wait_ready(2000, "rB_w");
    check_results(-1, "rB_w");

    // Dot channel silent on cs=2
    silent_en = 1'b1; silent_cs = 4'd2;
    got_cs.delete(); got_q.delete();
    send_window(1'b0, BEATS, "to");
`ifdef FEEDER_TIMEOUT_EN
    wait_ready(2000, "to");
    check_results(2, "to");
    chk("to_err_sticky", 64'(err), 64'd1);
`else
    wait_cs_run(4'd2, "to");
    repeat (60) @(negedge clk);
    chk("to_stuck_load", 64'(load), 64'd1);
    chk("to_stuck_cs", 64'(cs), 64'd2);
    chk("to_no_err", 64'(err), 64'd0);
    chk("to_res_count", 64'(got_cs.size()), 64'd2);
`endif
    silent_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_err_clear", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
